// File: rtl/inv_key_scheduler_if.sv
// inv_key_scheduler_if: key-load request and round-key ready/valid stream
interface inv_key_scheduler_if;
  logic         start;
  logic [255:0] last_key_in;
  logic         busy;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         rk_valid;
  logic         rk_ready;
  logic         done;
  modport master (output start, last_key_in, rk_ready, input busy, rk_out, rk_idx, rk_valid, done);
  modport slave  (input start, last_key_in, rk_ready, output busy, rk_out, rk_idx, rk_valid, done);
endinterface

// File: rtl/inv_key_scheduler.sv
// inv_key_scheduler: rebuilds the AES-256 schedule backwards from {rk13, rk14}, emitting rk14..rk0
module inv_key_scheduler (
  input  logic               clk,
  input  logic               rst_n,
  inv_key_scheduler_if.slave bus
);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t       state, state_n;
  logic [127:0] win_hi, win_lo, prev;
  logic [3:0]   r;
  logic         done_q, load, xfer;
  logic [31:0]  k3, n0, n1, n2, n3, sub_in, sub_out;
  logic [7:0]   rcon;
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // The S-box is computed as GF(2^8) inverse (a^254) followed by the affine map, so no ROM is needed.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] a2, a3, a12, a15, a240, inv;
    a2   = gmul(a, a);
    a3   = gmul(a2, a);
    a12  = gmul(gmul(a3, a3), gmul(a3, a3));
    a15  = gmul(a12, a3);
    a240 = gmul(gmul(gmul(a15, a15), gmul(a15, a15)), gmul(gmul(a15, a15), gmul(a15, a15)));
    a240 = gmul(a240, a240);
    inv  = gmul(gmul(a240, a12), a2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction
  assign load    = state == IDLE && bus.start;
  assign xfer    = state == EMIT && bus.rk_ready;
  assign k3      = win_hi[31:0];
  assign n0      = win_lo[127:96];
  assign n1      = win_lo[95:64];
  assign n2      = win_lo[63:32];
  assign n3      = win_lo[31:0];
  assign sub_in  = r[0] ? k3 : {k3[23:0], k3[31:24]};
  assign sub_out = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
  assign rcon    = r[0] ? 8'h00 : 8'h01 << (r[3:1] - 3'd1);
  assign prev    = r == 4'd1 ? '0 : {n0 ^ sub_out ^ {rcon, 24'h0}, n1 ^ n0, n2 ^ n1, n3 ^ n2};
  // State register.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // Enter EMIT on a load; return to IDLE once rk0 is taken.
  always_comb state_n = load ? EMIT : (xfer && r == 4'd0) ? IDLE : state;
  // Outputs come straight from state and window registers.
  always_comb begin
    bus.busy     = state == EMIT;
    bus.rk_valid = state == EMIT;
    bus.rk_out   = win_lo;
    bus.rk_idx   = r;
    bus.done     = done_q;
  end
  // Key window slides down one round per accepted transfer; done pulses after the rk0 transfer.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      win_hi <= '0;
      win_lo <= '0;
      r      <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= xfer && r == 4'd0;
      if (load) begin
        win_hi <= bus.last_key_in[255:128];
        win_lo <= bus.last_key_in[127:0];
        r      <= 4'd14;
      end else if (xfer && r != 4'd0) begin
        win_lo <= win_hi;
        win_hi <= prev;
        r      <= r - 4'd1;
      end
    end
endmodule

// File: tb/tb_inv_key_scheduler.sv
// tb_inv_key_scheduler: scoreboard bench comparing emitted round keys with a forward AES-256 expansion
module tb_inv_key_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rand_mode = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [131:0] q[$];
  logic [127:0] exp_rk [15];
  logic expect_done = 1'b0;
  logic held = 1'b0;
  logic [127:0] hold_key;
  logic [3:0] hold_idx;
  localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  logic [127:0] sbox_rows [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  inv_key_scheduler_if bus ();
  inv_key_scheduler dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [127:0] row;
    row = sbox_rows[x[7:4]];
    return row[127 - 8 * x[3:0] -: 8];
  endfunction
  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
  endfunction
  task automatic expand(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255 - 32 * i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i - 1];
      if (i % 8 == 0) begin
        t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = rc << 1;
      end else if (i % 8 == 4) t = subword(t);
      w[i] = w[i - 8] ^ t;
    end
    for (int k = 0; k < 15; k++) exp_rk[k] = {w[4 * k], w[4 * k + 1], w[4 * k + 2], w[4 * k + 3]};
  endtask
  task automatic check_model(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask
  task automatic load(input logic [255:0] key);
    expand(key);
    for (int k = 14; k >= 0; k--) q.push_back({4'(k), exp_rk[k]});
    bus.start = 1'b1;
    bus.last_key_in = {exp_rk[13], exp_rk[14]};
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checks++;
    if (bus.rk_valid !== 1'b1 || bus.rk_idx !== 4'd14) begin
      errors++;
      $display("FAIL load_latency valid=%b idx=%0d want valid=1 idx=14", bus.rk_valid, bus.rk_idx);
    end
  endtask
  task automatic wait_done();
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) return;
    end
    checks++;
    errors++;
    $display("FAIL done_timeout done=%b want 1 within 1000 cycles", bus.done);
  endtask
  task automatic wait_idx(input logic [3:0] idx);
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk);
      #1;
      if (bus.rk_valid === 1'b1 && bus.rk_idx === idx) return;
    end
    checks++;
    errors++;
    $display("FAIL idx_timeout idx=%0d want %0d", bus.rk_idx, idx);
  endtask
  function automatic logic [255:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction
  // Consumer: always ready, or ready on roughly 30% of cycles.
  always @(posedge clk) begin
    #1;
    bus.rk_ready = rand_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
  end
  // Monitor: reset values, done pulse, hold stability and in-order key scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      checks++;
      if (bus.rk_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rk_idx !== 4'd0 || bus.rk_out !== 128'h0) begin
        errors++;
        $display("FAIL reset_values valid=%b busy=%b done=%b idx=%0d key=%h want all zero", bus.rk_valid, bus.busy, bus.done, bus.rk_idx, bus.rk_out);
      end
      expect_done = 1'b0;
      held = 1'b0;
    end else begin
      checks++;
      if (bus.done !== expect_done) begin
        errors++;
        $display("FAIL done_pulse got %b want %b", bus.done, expect_done);
      end
      expect_done = 1'b0;
      if (held) begin
        checks++;
        if (bus.rk_valid !== 1'b1 || bus.rk_out !== hold_key || bus.rk_idx !== hold_idx) begin
          errors++;
          $display("FAIL hold_stable got valid=%b idx=%0d %h want valid=1 idx=%0d %h", bus.rk_valid, bus.rk_idx, bus.rk_out, hold_idx, hold_key);
        end
      end
      held = bus.rk_valid === 1'b1 && bus.rk_ready === 1'b0;
      hold_key = bus.rk_out;
      hold_idx = bus.rk_idx;
      if (bus.rk_valid === 1'b1 && bus.rk_ready === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_key got idx=%0d %h want no transfer", bus.rk_idx, bus.rk_out);
        end else begin
          logic [131:0] e;
          e = q.pop_front();
          if ({bus.rk_idx, bus.rk_out} !== e) begin
            errors++;
            $display("FAIL round_key got idx=%0d %h want idx=%0d %h", bus.rk_idx, bus.rk_out, e[131:128], e[127:0]);
          end
        end
        if (bus.rk_idx === 4'd0) expect_done = 1'b1;
      end
    end
  end
  initial begin
    bus.start = 1'b0;
    bus.last_key_in = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    expand(C3_KEY);
    check_model("model_rk0", exp_rk[0], 128'h000102030405060708090a0b0c0d0e0f);
    check_model("model_rk1", exp_rk[1], 128'h101112131415161718191a1b1c1d1e1f);
    check_model("model_rk2", exp_rk[2], 128'ha573c29fa176c498a97fce93a572c09c);
    check_model("model_rk13", exp_rk[13], 128'h4e5a6699a9f24fe07e572baacdf8cdea);
    check_model("model_rk14", exp_rk[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);
    load(C3_KEY);
    wait_done();
    load(rand_key());
    wait_done();
    rand_mode = 1'b1;
    load(C3_KEY);
    wait_done();
    rand_mode = 1'b0;
    load(C3_KEY);
    wait_idx(4'd7);
    bus.start = 1'b1;
    bus.last_key_in = rand_key();
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL start_in_emit busy=%b want 1", bus.busy);
    end
    wait_done();
    rand_mode = 1'b1;
    load(C3_KEY);
    wait_idx(4'd5);
    rst_n = 1'b0;
    q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rand_mode = 1'b0;
    load(C3_KEY);
    wait_done();
    for (int i = 0; i < 200; i++) begin
      rand_mode = i % 5 == 0;
      load(rand_key());
      wait_done();
    end
    rand_mode = 1'b0;
    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL leftover_keys got %0d want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/inv_key_scheduler.md
# inv_key_scheduler

Streaming reverse AES-256 key scheduler for the decrypt datapath. It is loaded once with the final two round keys (rk13, rk14) and regenerates the schedule backwards, one round key per accepted handshake, in the order rk14, rk13, …, rk0. Only a 256-bit window is held, not a 15-entry array. It sits between the key-load path and the inverse-round pipeline, which consumes keys in exactly this order.

## Interface
- No parameters. AES-256 only: 15 round keys, 128-bit each.
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  load request; honoured only in IDLE.
- last_key_in  input  256  {rk13, rk14}, with rk13 in bits [255:128].
- busy  output  1  high in EMIT state.
- rk_out  output  128  current round key.
- rk_idx  output  4  round index of rk_out, 14 down to 0.
- rk_valid  output  1  rk_out/rk_idx valid.
- rk_ready  input  1  consumer accepts; transfer occurs when rk_valid & rk_ready.
- done  output  1  one-cycle pulse after rk0 transfers.

## Operation
- Word notation: a key is 4 × 32-bit words, with w0 in the MSBs. SubWord applies the S-box per byte. RotWord is {w[23:0], w[31:24]}. Rcon is XORed into byte [31:24].
- Registers:
  - win_hi: rk[r-1].
  - win_lo: rk[r].
  - r: 4-bit index.
  - state: IDLE or EMIT.
- Outputs are driven directly from registers: rk_out = win_lo, rk_idx = r.
- IDLE:
  - On start: win_hi ← last_key_in[255:128], win_lo ← last_key_in[127:0], r ← 14, rk_valid ← 1, busy ← 1, state ← EMIT.
  - start with an X on last_key_in is the caller's error; no checking is done.
- EMIT with no transfer: all registers hold. rk_out and rk_idx stay stable while rk_valid & !rk_ready.
- EMIT transfer with r ≥ 1: win_lo ← win_hi, win_hi ← prev, r ← r−1. prev = rk[r−2] is computed combinationally from win_hi = {k0..k3} and win_lo = {n0..n3}.
  - r even, r ≥ 2 (inverse even step):
    - p3 = n3^n2, p2 = n2^n1, p1 = n1^n0.
    - p0 = n0 ^ SubWord(RotWord(k3)) ^ rcon, with rcon = 8'h01 << (r/2 − 1): r=2 gives 01, r=14 gives 40.
  - r odd, r ≥ 3 (inverse odd step):
    - p3 = n3^n2, p2 = n2^n1, p1 = n1^n0.
    - p0 = n0 ^ SubWord(k3), with no rotate and no rcon.
  - r = 1: win_hi ← don't care. Implementations drive 0; rcon and S-box results are unused.
- EMIT transfer with r = 0: rk_valid ← 0, busy ← 0, done ← 1 for one cycle, r ← 0, state ← IDLE.
- start while EMIT: ignored, and the current sequence is unaffected.
- start in the same cycle as the done pulse: accepted, because state is already IDLE in that cycle.
- S-boxes: only one SubWord instance (4 byte S-boxes) is used; the even and odd paths share it through a mux on the input word.

## Timing
- Reset values:
  - state = IDLE, busy = 0, rk_valid = 0, done = 0, rk_idx = 0.
  - rk_out = 0, win_hi = 0.
- Load latency: start sampled at edge N gives rk_valid = 1 with rk14 after edge N.
- Throughput: one key per cycle while rk_ready = 1. With rk_ready held high, the sequence is 15 consecutive transfers, and done follows the cycle after the rk0 transfer.
- Critical path: win regs → S-box → XOR → win_hi. No multicycle paths.
- Reset asserted mid-sequence: immediate return to reset values. No done pulse, and no partial key is held.
- rk_ready may toggle arbitrarily. rk_valid never drops before the rk0 transfer.

## Test plan
- Load last_key_in = {4e5a6699a9f24fe07e572baacdf8cdea, 24fc79ccbf0979e9371ac23c6d68de36} (FIPS-197 C.3 key) with rk_ready = 1. Required response:
  - rk_idx 14 → rk_out 24fc79cc…6d68de36.
  - rk_idx 13 → 4e5a6699….
  - rk_idx 2 → a573c29fa176c498a97fce93a572c09c.
  - rk_idx 1 → 101112131415161718191a1b1c1d1e1f.
  - rk_idx 0 → 000102030405060708090a0b0c0d0e0f.
  - done is high exactly one cycle later.
- Same load, with rk_ready random at 30% duty: the sequence matches the above exactly, and rk_out is stable on every valid & !ready cycle.
- Pulse start at rk_idx = 7 with a different key: the output sequence is unchanged, and busy stays 1.
- Assert rst_n low at rk_idx = 5, then release and load the C.3 keys: the outputs are at reset values during reset, then a full correct 15-key sequence with no stale data.
- Raise start on the done cycle with a second key: rk14 of the second key appears on the next cycle, with no idle gap beyond that cycle.
- Random 256-bit keys (≥ 200): expand forward in the model, load {rk13, rk14}, and compare all 15 outputs against the model.
